// File: rtl/event_packetizer.sv
// Event packetizer: turns a one-hot channel grant into {ch_idx, ts, data} packets held in a FWFT FIFO.
// Optional EVENT_PKT_PARITY_EN prepends an even-parity MSB computed at capture.
module event_packetizer #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned TS_W  = 12,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(N_CH),
  localparam int unsigned LW   = $clog2(DEPTH) + 1,
`ifdef EVENT_PKT_PARITY_EN
  localparam int unsigned PAR_W = 1,
`else
  localparam int unsigned PAR_W = 0,
`endif
  localparam int unsigned PKT_W = CW + TS_W + DW + PAR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N_CH-1:0]      ch_sel_i,
  input  logic [N_CH*DW-1:0]   ch_data_i,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [PKT_W-1:0]     pkt_data_o,
  output logic [LW-1:0]        level_o,
  output logic                 overflow_o,
  output logic                 onehot_err_o,
  input  logic                 clr_err_i
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned RAW_W = CW + TS_W + DW;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             onehot_err_q, onehot_err_d;
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic [CW-1:0]    idx_c;
  logic [DW-1:0]    sample_c;
  logic [RAW_W-1:0] raw_c;
  logic [PKT_W-1:0] pkt_c;
  logic             push_req_c, multi_c, full_c, pop_c, push_ok_c;

  // Lowest set bit of the grant wins
  always_comb begin
    idx_c = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_sel_i[i]) idx_c = CW'(i);
    end
  end

  assign sample_c   = ch_data_i[idx_c*DW +: DW];
  assign raw_c      = {idx_c, ts_q, sample_c};
`ifdef EVENT_PKT_PARITY_EN
  assign pkt_c      = {^raw_c, raw_c};
`else
  assign pkt_c      = raw_c;
`endif

  assign push_req_c = en_i && (ch_sel_i != '0);
  assign multi_c    = |(ch_sel_i & (ch_sel_i - N_CH'(1)));
  assign full_c     = (count_q == LW'(DEPTH));
  assign pop_c      = (count_q != '0) && pkt_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok_c  = push_req_c && (!full_c || pop_c);

  always_comb begin
    ts_d         = ts_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + LW'(push_ok_c) - LW'(pop_c);
    overflow_d   = overflow_q && !clr_err_i;
    onehot_err_d = onehot_err_q && !clr_err_i;
    if (en_i)      ts_d     = ts_q + TS_W'(1);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_req_c && !push_ok_c) overflow_d   = 1'b1;
    if (en_i && multi_c)          onehot_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      onehot_err_q <= onehot_err_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= pkt_c;
  end

  assign pkt_valid_o  = (count_q != '0);
  assign pkt_data_o   = pkt_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o      = count_q;
  assign overflow_o   = overflow_q;
  assign onehot_err_o = onehot_err_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer (TS_W=4 so timestamp wrap is reachable quickly).
module tb_event_packetizer;

  localparam int unsigned N_CH  = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned TS_W  = 4;
  localparam int unsigned DEPTH = 4;
`ifdef EVENT_PKT_PARITY_EN
  localparam int unsigned PKT_W = 17;
`else
  localparam int unsigned PKT_W = 16;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic [N_CH-1:0]     ch_sel_i;
  logic [N_CH*DW-1:0]  ch_data_i;
  logic                pkt_valid_o;
  logic                pkt_ready_i;
  logic [PKT_W-1:0]    pkt_data_o;
  logic [2:0]          level_o;
  logic                overflow_o;
  logic                onehot_err_o;
  logic                clr_err_i;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  ts_m;
  logic [3:0]  ts_rec [16];

  event_packetizer #(.N_CH(N_CH), .DW(DW), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .ch_sel_i(ch_sel_i),
    .ch_data_i(ch_data_i), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_data_o(pkt_data_o), .level_o(level_o), .overflow_o(overflow_o),
    .onehot_err_o(onehot_err_o), .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input int idx, input logic [3:0] ts, input logic [7:0] d);
    logic [15:0] r;
    logic [31:0] p;
    r = {4'(idx), ts, d};
    p = 32'(r);
`ifdef EVENT_PKT_PARITY_EN
    p[16] = ^r;
`endif
    return p;
  endfunction

  // One clock; the model timestamp advances whenever en_i was high at the edge
  task automatic step();
    @(posedge clk_i);
    if (!rst_i && en_i) ts_m = ts_m + 4'd1;
    #1;
  endtask

  task automatic grant(input int k, input logic [7:0] v, output logic [3:0] ts_at);
    en_i = 1'b1;
    ch_sel_i = N_CH'(1) << k;
    ch_data_i[k*DW +: DW] = v;
    ts_at = ts_m;
    step();
    en_i = 1'b0;
    ch_sel_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    ts_m = '0;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] t;
    en_i = 0; ch_sel_i = '0; ch_data_i = '0; pkt_ready_i = 0; clr_err_i = 0; ts_m = '0;
    do_reset();
    check("rst_valid", 32'(pkt_valid_o), 0);
    check("rst_level", 32'(level_o), 0);
    check("rst_data", 32'(pkt_data_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_err", 32'(onehot_err_o), 0);

    // 1: advance ts to 5, grant ch3
    en_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    grant(3, 8'hA5, t);
    check("t1_valid", 32'(pkt_valid_o), 1);
    check("t1_pkt", 32'(pkt_data_o), mk_pkt(3, 4'd5, 8'hA5));
    check("t1_level", 32'(level_o), 1);
    pkt_ready_i = 1'b1;
    step();
    pkt_ready_i = 1'b0;
    check("t1_drained", 32'(pkt_valid_o), 0);

    // 2: six grants with consumer stalled -> two dropped
    for (int i = 0; i < 6; i++) grant(i, 8'(8'h10 + i), ts_rec[i]);
    check("t2_level", 32'(level_o), 4);
    check("t2_ovf", 32'(overflow_o), 1);
    pkt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_valid", 32'(pkt_valid_o), 1);
      check("t2_pkt", 32'(pkt_data_o), mk_pkt(i, ts_rec[i], 8'(8'h10 + i)));
      step();
    end
    pkt_ready_i = 1'b0;
    check("t2_empty", 32'(pkt_valid_o), 0);
    check("t2_level0", 32'(level_o), 0);
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    check("t2_ovf_clr", 32'(overflow_o), 0);

    // 3: full FIFO, push and pop together
    for (int i = 8; i < 12; i++) grant(i, 8'(8'h80 + i), ts_rec[i]);
    check("t3_full", 32'(level_o), 4);
    pkt_ready_i = 1'b1;
    grant(12, 8'h8C, ts_rec[12]);
    pkt_ready_i = 1'b0;
    check("t3_level", 32'(level_o), 4);
    check("t3_ovf", 32'(overflow_o), 0);
    pkt_ready_i = 1'b1;
    for (int i = 9; i < 13; i++) begin
      check("t3_pkt", 32'(pkt_data_o), mk_pkt(i, ts_rec[i], 8'(8'h80 + i)));
      step();
    end
    pkt_ready_i = 1'b0;
    check("t3_empty", 32'(level_o), 0);

    // 4: multi-hot grant, clear, then set-wins-over-clear
    en_i = 1'b1; ch_sel_i = 16'h0110; ch_data_i[4*DW +: DW] = 8'h3C; t = ts_m;
    step();
    en_i = 1'b0; ch_sel_i = '0;
    check("t4_err", 32'(onehot_err_o), 1);
    check("t4_pkt", 32'(pkt_data_o), mk_pkt(4, t, 8'h3C));
    clr_err_i = 1'b1;
    step();
    check("t4_err_clr", 32'(onehot_err_o), 0);
    en_i = 1'b1; ch_sel_i = 16'h0003;
    step();
    en_i = 1'b0; ch_sel_i = '0;
    check("t4_set_wins", 32'(onehot_err_o), 1);
    step();
    clr_err_i = 1'b0;
    check("t4_err_clr2", 32'(onehot_err_o), 0);
    check("t4_level", 32'(level_o), 2);
    pkt_ready_i = 1'b1;
    step(); step();
    pkt_ready_i = 1'b0;

    // 5: timestamp wrap and hold while disabled
    en_i = 1'b1;
    if (ts_m == 4'd0) step();
    for (int i = 0; i < 16 && ts_m != 4'd0; i++) step();
    grant(7, 8'h77, t);
    check("t5_pkt_wrap", 32'(pkt_data_o), mk_pkt(7, 4'd0, 8'h77));
    ch_sel_i = 16'h0002;
    for (int i = 0; i < 3; i++) step();
    ch_sel_i = '0;
    check("t5_no_push", 32'(level_o), 1);
    pkt_ready_i = 1'b1;
    step();
    pkt_ready_i = 1'b0;
    grant(2, 8'h22, t);
    check("t5_ts_frozen", 32'(pkt_data_o), mk_pkt(2, 4'd1, 8'h22));
    pkt_ready_i = 1'b1;
    step();
    pkt_ready_i = 1'b0;

    // 6: asynchronous reset with packets queued
    for (int i = 0; i < 3; i++) grant(i + 5, 8'(8'h50 + i), t);
    check("t6_level3", 32'(level_o), 3);
    #2 rst_i = 1'b1;
    #1;
    check("t6_level", 32'(level_o), 0);
    check("t6_valid", 32'(pkt_valid_o), 0);
    check("t6_data", 32'(pkt_data_o), 0);
    do_reset();
    check("t6_after", 32'(pkt_valid_o), 0);
    grant(1, 8'h11, t);
    check("t6_ts_reset", 32'(pkt_data_o), mk_pkt(1, 4'd0, 8'h11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
